// File: rtl/preproc_frame_stats_pkg.sv
// Shared record layout, word indices and FSM state types for the frame statistics stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package preproc_frame_stats_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int REC_WORDS = 8;
  localparam int IDX_W     = 3;

  // Word positions inside the 8-word result record
  localparam int W_HDR    = 0;
  localparam int W_MIN    = 1;
  localparam int W_MAX    = 2;
  localparam int W_MOTION = 3;
  localparam int W_EDGE   = 4;
  localparam int W_COL1   = 5;
  localparam int W_COL2   = 6;
  localparam int W_COL3   = 7;

  // Header word field offsets
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_DROP_BIT = 17;
  localparam int HDR_BBOX_BIT = 16;

  typedef logic [31:0] word_t;
  typedef word_t [REC_WORDS-1:0] rec_t;

  typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN = 1'b1} acc_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

  // Header without drop_seen; the sender ORs that bit in when the record is loaded.
  function automatic word_t pack_hdr(input logic bbox_valid, input logic [15:0] frame_num);
    word_t w;
    w = '0;
    w[HDR_SYNC_LSB +: 8] = SYNC_BYTE;
    w[HDR_BBOX_BIT]      = bbox_valid;
    w[15:0]              = frame_num;
    return w;
  endfunction

endpackage

// File: rtl/preproc_frame_stats_if.sv
// Pixel-flag input stream plus result-word output stream of the frame statistics stage.
// Latency: n/a (bundle of wires).
// Backpressure: o_wvalid/i_wready on the result side; pixel side has no backpressure.
// Ports: i_* pixel strobe, sof/eof, coords and flags; o_wdata/o_wvalid/o_wlast with i_wready;
//        o_drop_cnt and o_busy status. slave = the stats block, master = the pixel source/host.
interface preproc_frame_stats_if #(
  parameter int X_W = 12,
  parameter int Y_W = 11
);
  logic           i_valid;
  logic           i_sof;
  logic           i_eof;
  logic [X_W-1:0] i_x;
  logic [Y_W-1:0] i_y;
  logic           i_edge;
  logic           i_motion;
  logic [1:0]     i_color;
  logic [31:0]    o_wdata;
  logic           o_wvalid;
  logic           o_wlast;
  logic           i_wready;
  logic [7:0]     o_drop_cnt;
  logic           o_busy;

  modport slave (
    input  i_valid, i_sof, i_eof, i_x, i_y, i_edge, i_motion, i_color, i_wready,
    output o_wdata, o_wvalid, o_wlast, o_drop_cnt, o_busy
  );

  modport master (
    output i_valid, i_sof, i_eof, i_x, i_y, i_edge, i_motion, i_color, i_wready,
    input  o_wdata, o_wvalid, o_wlast, o_drop_cnt, o_busy
  );
endinterface

// File: rtl/preproc_frame_stats_tx.sv
// Record snapshot, 8-word serializer and dropped-frame counter.
// Latency: load_vld at edge E -> word 0 valid right after E.
// Backpressure: word held until wready; a load arriving while sending is dropped and counted.
// Ports: clk/rst; load_vld/load_dat snapshot request; wready in; wdata/wvalid/wlast out;
//        drop_cnt (saturating at 255) and busy out.
module preproc_frame_stats_tx
  import preproc_frame_stats_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_vld,
  input  rec_t       load_dat,
  input  logic       wready,
  output word_t      wdata,
  output logic       wvalid,
  output logic       wlast,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  tx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  rec_t              snap_q, snap_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              drop_seen_q, drop_seen_d;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_WORDS - 1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    drop_cnt_d  = drop_cnt_q;
    drop_seen_d = drop_seen_q;

    if (state_q == TX_SEND && wready) begin
      if (idx_q == LAST_IDX) begin
        state_d = TX_IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Only an idle sender takes a new snapshot; the word being accepted this
    // very cycle still counts as busy, so that frame is dropped.
    if (load_vld) begin
      if (state_q == TX_IDLE) begin
        snap_d = load_dat;
        snap_d[W_HDR][HDR_DROP_BIT] = load_dat[W_HDR][HDR_DROP_BIT] | drop_seen_q;
        drop_seen_d = 1'b0;
        state_d     = TX_SEND;
        idx_d       = '0;
      end else begin
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        drop_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      drop_cnt_q  <= '0;
      drop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_seen_q <= drop_seen_d;
    end
  end

  // All outputs decode flops only; data is forced to zero while not valid.
  assign wvalid   = (state_q == TX_SEND);
  assign wdata    = wvalid ? snap_q[idx_q] : '0;
  assign wlast    = wvalid && (idx_q == LAST_IDX);
  assign drop_cnt = drop_cnt_q;
  assign busy     = wvalid;

endmodule

// File: rtl/preproc_frame_stats.sv
// Per-frame motion bounding box and flag counters, emitted as an 8-word record per frame.
// Latency: eof pixel in cycle N -> snapshot at end of N+1 -> word 0 valid in cycle N+2.
// Backpressure: result words stall on i_wready; pixels never stall, frames ending while busy are dropped.
// Ports: clk, rst (async, active-high); bus = pixel stream in, result stream and status out.
module preproc_frame_stats
  import preproc_frame_stats_pkg::*;
#(
  parameter int X_W     = 12,
  parameter int Y_W     = 11,
  parameter int CNT_W   = 22,
  parameter int MIN_PIX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  preproc_frame_stats_if.slave  bus
);

  acc_state_t                 acc_state_q, acc_state_d;
  logic [X_W-1:0]             xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0]             ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]           motion_cnt_q, motion_cnt_d;
  logic [CNT_W-1:0]           edge_cnt_q, edge_cnt_d;
  logic [3:1][CNT_W-1:0]      col_cnt_q, col_cnt_d;
  logic                       eof_pend_q, eof_pend_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;

  logic                       take;
  logic                       bbox_valid;
  rec_t                       rec;

  word_t                      tx_wdata;
  logic                       tx_wvalid;
  logic                       tx_wlast;
  logic [7:0]                 tx_drop_cnt;
  logic                       tx_busy;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    acc_state_d  = acc_state_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    motion_cnt_d = motion_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    col_cnt_d    = col_cnt_q;
    eof_pend_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // Every completed frame is numbered, whether or not its record gets sent.
    if (eof_pend_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // sof is honoured in either state; in ACC_RUN it silently restarts the frame.
    take = bus.i_valid && (acc_state_q == ACC_RUN || bus.i_sof);

    if (take) begin
      if (bus.i_sof) begin
        xmin_d       = '1;
        ymin_d       = '1;
        xmax_d       = '0;
        ymax_d       = '0;
        motion_cnt_d = '0;
        edge_cnt_d   = '0;
        col_cnt_d    = '0;
      end

      if (bus.i_motion) begin
        motion_cnt_d = sat_inc(motion_cnt_d);
        if (bus.i_x < xmin_d) xmin_d = bus.i_x;
        if (bus.i_x > xmax_d) xmax_d = bus.i_x;
        if (bus.i_y < ymin_d) ymin_d = bus.i_y;
        if (bus.i_y > ymax_d) ymax_d = bus.i_y;
      end

      if (bus.i_edge) begin
        edge_cnt_d = sat_inc(edge_cnt_d);
      end

      if (bus.i_color != 2'd0) begin
        col_cnt_d[bus.i_color] = sat_inc(col_cnt_d[bus.i_color]);
      end

      // Accumulators hold their final values for one cycle while the
      // snapshot is taken, even if the next frame's sof lands right then.
      acc_state_d = bus.i_eof ? ACC_IDLE : ACC_RUN;
      eof_pend_d  = bus.i_eof;
    end
  end

  always_comb begin
    bbox_valid        = (motion_cnt_q >= CNT_W'(MIN_PIX));
    rec               = '0;
    rec[W_HDR]        = pack_hdr(bbox_valid, frame_cnt_d);
    rec[W_MIN]        = {16'(xmin_q), 16'(ymin_q)};
    rec[W_MAX]        = {16'(xmax_q), 16'(ymax_q)};
    rec[W_MOTION]     = 32'(motion_cnt_q);
    rec[W_EDGE]       = 32'(edge_cnt_q);
    rec[W_COL1]       = 32'(col_cnt_q[1]);
    rec[W_COL2]       = 32'(col_cnt_q[2]);
    rec[W_COL3]       = 32'(col_cnt_q[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state_q  <= ACC_IDLE;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      motion_cnt_q <= '0;
      edge_cnt_q   <= '0;
      col_cnt_q    <= '0;
      eof_pend_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      acc_state_q  <= acc_state_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      motion_cnt_q <= motion_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      col_cnt_q    <= col_cnt_d;
      eof_pend_q   <= eof_pend_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  preproc_frame_stats_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .load_vld (eof_pend_q),
    .load_dat (rec),
    .wready   (bus.i_wready),
    .wdata    (tx_wdata),
    .wvalid   (tx_wvalid),
    .wlast    (tx_wlast),
    .drop_cnt (tx_drop_cnt),
    .busy     (tx_busy)
  );

  assign bus.o_wdata    = tx_wdata;
  assign bus.o_wvalid   = tx_wvalid;
  assign bus.o_wlast    = tx_wlast;
  assign bus.o_drop_cnt = tx_drop_cnt;
  assign bus.o_busy     = tx_busy;

endmodule
